// File: rtl/pattern_serializer_tx_if.sv
// Parallel-in / serial-out handshake bundle for pattern_serializer_tx.
// master drives the burst request; slave (the serializer) drives the serial line and status.
interface pattern_serializer_tx_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt,
    input  data_out, data_valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt,
    output data_out, data_valid, busy, done
  );
endinterface

// File: rtl/pattern_serializer_tx.sv
// Serial bit-pattern transmitter: MSB-first frames, repeated N times with optional idle gaps.
// Define PATTERN_PARITY_EN to append an even-parity bit to every frame.
module pattern_serializer_tx #(
  parameter int WIDTH      = 3,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pattern_serializer_tx_if.slave bus
);

`ifdef PATTERN_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] frames, frames_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       gap_cnt, gap_n;

  logic data_out_q, data_valid_q, busy_q, done_q;
  logic data_out_d, data_valid_d, busy_d, done_d;

  // Bit idx of a frame counts down to 0; with parity, position 0 is the parity bit.
  function automatic logic frame_bit(input logic [WIDTH-1:0] s, input logic [IDX_W-1:0] i);
`ifdef PATTERN_PARITY_EN
    logic [IDX_W-1:0] sel;
    sel = i - IDX_W'(1);
    return (i == '0) ? ^s : s[sel];
`else
    return s[i];
`endif
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      shadow       <= '0;
      frames       <= '0;
      idx          <= '0;
      gap_cnt      <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      shadow       <= shadow_n;
      frames       <= frames_n;
      idx          <= idx_n;
      gap_cnt      <= gap_n;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_n  = state;
    shadow_n = shadow;
    frames_n = frames;
    idx_n    = idx;
    gap_n    = gap_cnt;
    unique case (state)
      IDLE: begin
        if (bus.start && (bus.repeat_cnt != '0)) begin
          state_n  = SHIFT;
          shadow_n = bus.pattern;
          frames_n = bus.repeat_cnt;
          idx_n    = IDX_LAST;
        end
      end
      SHIFT: begin
        if (idx != '0) begin
          idx_n = idx - IDX_W'(1);
        end else if (frames == CNT_W'(1)) begin
          state_n = DONE;
        end else begin
          frames_n = frames - CNT_W'(1);
          idx_n    = IDX_LAST;
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = SHIFT;
          idx_n   = IDX_LAST;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are pure Moore signals.
  always_comb begin
    data_valid_d = (state_n == SHIFT);
    busy_d       = (state_n == SHIFT) || (state_n == GAP);
    done_d       = (state_n == DONE);
    data_out_d   = data_valid_d && frame_bit(shadow_n, idx_n);
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pattern_serializer_tx.sv
// Scoreboard bench for pattern_serializer_tx: one instance without gaps, one with GAP_CYCLES=2.
// Expected serial bits are queued at stimulus time and popped whenever data_valid is seen.
module tb_pattern_serializer_tx;
  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
`ifdef PATTERN_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  pattern_serializer_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if0 ();
  pattern_serializer_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if2 ();

  pattern_serializer_tx #(.WIDTH(WIDTH), .GAP_CYCLES(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  pattern_serializer_tx #(.WIDTH(WIDTH), .GAP_CYCLES(2), .CNT_W(CNT_W)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  // Index 0 -> gapless instance, index 1 -> GAP_CYCLES=2 instance.
  logic             start_r [2];
  logic [WIDTH-1:0] pat_r   [2];
  logic [CNT_W-1:0] cnt_r   [2];
  logic out_w [2], valid_w [2], busy_w [2], done_w [2];

  assign if0.start      = start_r[0];
  assign if0.pattern    = pat_r[0];
  assign if0.repeat_cnt = cnt_r[0];
  assign if2.start      = start_r[1];
  assign if2.pattern    = pat_r[1];
  assign if2.repeat_cnt = cnt_r[1];
  assign out_w[0]   = if0.data_out;
  assign valid_w[0] = if0.data_valid;
  assign busy_w[0]  = if0.busy;
  assign done_w[0]  = if0.done;
  assign out_w[1]   = if2.data_out;
  assign valid_w[1] = if2.data_valid;
  assign busy_w[1]  = if2.busy;
  assign done_w[1]  = if2.done;

  bit q0[$];
  bit q1[$];
  int done_seen [2] = '{0, 0};
  int done_exp  [2] = '{0, 0};
  bit mon_en = 1'b0;
  int mon_sz;
  bit mon_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic push_bit(input int d, input bit b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic push_frames(input int d, input logic [WIDTH-1:0] pat, input int n);
    for (int f = 0; f < n; f++) begin
      for (int b = WIDTH - 1; b >= 0; b--) push_bit(d, pat[b]);
`ifdef PATTERN_PARITY_EN
      push_bit(d, ^pat);
`endif
    end
  endtask

  // Monitor: pop one expected bit per valid cycle; line must be 0 when not valid.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (done_w[d] === 1'b1) done_seen[d]++;
        if (valid_w[d] === 1'b1) begin
          mon_sz = (d == 0) ? q0.size() : q1.size();
          check($sformatf("sb_has_exp%0d", d), mon_sz > 0, 1);
          if (mon_sz > 0) begin
            if (d == 0) mon_b = q0.pop_front();
            else        mon_b = q1.pop_front();
            check($sformatf("bit%0d", d), out_w[d], mon_b);
          end
        end else begin
          check($sformatf("idle_zero%0d", d), out_w[d], 0);
        end
      end
    end
  end

  task automatic run_burst(input int d, input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] n,
                           input int intf_at, input logic [WIDTH-1:0] intf_pat,
                           input bit start_in_done);
    int exp_busy;
    int busy_n;
    int c;
    push_frames(d, pat, int'(n));
    exp_busy = int'(n) * FL + (int'(n) - 1) * gap_of(d);
    done_exp[d]++;
    @(posedge clk); #1;
    start_r[d] = 1'b1;
    pat_r[d]   = pat;
    cnt_r[d]   = n;
    @(posedge clk); #1;
    start_r[d] = 1'b0;
    pat_r[d]   = ~pat;
    cnt_r[d]   = n + 1'b1;
    busy_n = 0;
    c      = 0;
    while (c < 4000) begin
      @(negedge clk);
      if (c == 0) begin
        check("first_valid", valid_w[d], 1);
        check("first_busy", busy_w[d], 1);
      end
      if (busy_w[d] !== 1'b1) break;
      busy_n++;
      start_r[d] = (c == intf_at);
      if (c == intf_at) pat_r[d] = intf_pat;
      c++;
    end
    check("busy_len", busy_n, exp_busy);
    check("done_pulse", done_w[d], 1);
    check("done_valid", valid_w[d], 0);
    start_r[d] = start_in_done;
    pat_r[d]   = intf_pat;
    @(negedge clk);
    start_r[d] = 1'b0;
    check("post_done", done_w[d], 0);
    check("post_busy", busy_w[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: nothing may start.
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_r[d] = 1'b1;
      pat_r[d]   = 3'b101;
      cnt_r[d]   = 8'd1;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_busy", busy_w[d], 0);
        check("rst_valid", valid_w[d], 0);
        check("rst_done", done_w[d], 0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("post_rst_idle", busy_w[d], 0);
    end

    // Single frame, no gap.
    run_burst(0, 3'b101, 8'd1, -1, 3'b000, 1'b0);
    // Two frames with a 2-cycle gap.
    run_burst(1, 3'b101, 8'd2, -1, 3'b000, 1'b0);
    // Back-to-back frames; start mid-burst and in DONE both ignored.
    run_burst(0, 3'b110, 8'd3, 3, 3'b011, 1'b1);

    // Zero repeat count is ignored.
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    pat_r[0]   = 3'b101;
    cnt_r[0]   = 8'd0;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("zero_busy", busy_w[0], 0);
      check("zero_valid", valid_w[0], 0);
      check("zero_done", done_w[0], 0);
    end

    // Abort with rst while the second bit is on the line.
    push_frames(0, 3'b101, 1);
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    pat_r[0]   = 3'b101;
    cnt_r[0]   = 8'd1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_2nd_valid", valid_w[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy_w[0], 0);
    check("abort_valid", valid_w[0], 0);
    check("abort_done", done_w[0], 0);
    check("abort_out", out_w[0], 0);
    #1;
    check("abort_residual", q0.size(), FL - 2);
    q0.delete();
    run_burst(0, 3'b111, 8'd1, -1, 3'b000, 1'b0);

    // Counter boundary and extra patterns.
    run_burst(1, WIDTH'($urandom_range(0, 7)), 8'd255, -1, 3'b000, 1'b0);
    run_burst(0, 3'b011, 8'd2, -1, 3'b100, 1'b0);
    run_burst(1, 3'b001, 8'd3, 5, 3'b111, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("done_count0", done_seen[0], done_exp[0]);
    check("done_count1", done_seen[1], done_exp[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_serializer_tx.md
Name: pattern_serializer_tx

Overview:
- Transmit side of the serial bit-pattern path.
- Captures a parallel WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clock, on a single serial line.
- Repeats the frame a programmable number of times, with an optional idle gap between frames.
- Drives the team's serial pattern detectors in loopback and system benches. The default pattern is 3'b101.

Parameters:
- WIDTH, 3, pattern length in bits (legal 2..32)
- GAP_CYCLES, 0, idle cycles inserted between consecutive frames (legal 0..255)
- CNT_W, 8, width of the repeat counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a burst; sampled only in IDLE
- pattern  input  WIDTH  pattern to send; captured when start is accepted
- repeat_cnt  input  CNT_W  number of frames to send; captured when start is accepted
- data_out  output  1  serial bit, MSB of pattern first
- data_valid  output  1  high on every cycle where data_out carries a pattern bit
- busy  output  1  high from the first bit through the last bit of the burst, including gaps
- done  output  1  single-cycle pulse after the last bit of the burst

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered (Moore-style), with no combinational path from inputs to outputs.
- Reset values: data_out=0, data_valid=0, busy=0, done=0. State=IDLE. Shadow pattern, frame counter and bit index are all 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - If start=1 and repeat_cnt!=0 at edge k: capture pattern and repeat_cnt into shadow registers and enter SHIFT.
  - After edge k: data_out=pattern[WIDTH-1], data_valid=1, busy=1. Latency is 1 cycle.
  - If start=1 and repeat_cnt==0: ignored. Stay in IDLE and do not pulse done.
- SHIFT:
  - Outputs one bit per cycle, from shadow[WIDTH-1] down to shadow[0]. data_valid=1, busy=1.
  - After bit 0 with frames remaining >1: go to GAP if GAP_CYCLES>0, otherwise start the next frame immediately (back-to-back, no bubble).
  - After bit 0 of the last frame: go to DONE.
- GAP:
  - Lasts exactly GAP_CYCLES cycles. data_out=0, data_valid=0, busy=1.
  - Then return to SHIFT with bit index reset to WIDTH-1.
- DONE:
  - One cycle: done=1, busy=0, data_valid=0, data_out=0.
  - Then go to IDLE.
  - start in the DONE cycle is ignored. The earliest accepted restart is the cycle after done.
- Total busy cycles: N*WIDTH + (N-1)*GAP_CYCLES, where N is the captured repeat_cnt. The done pulse follows immediately.
- start in SHIFT, GAP or DONE is ignored. Changes to pattern or repeat_cnt while busy have no effect on the burst in flight.
- Frame counter: counts down from N to 1. repeat_cnt = 2^CNT_W-1 must send exactly that many frames, with no wrap.
- rst during any state: on the next edge, return to the reset values. The burst is aborted and done is not pulsed. A fresh start is accepted on the first cycle after rst deasserts.
- data_out is 0 on every cycle where data_valid=0.

Optional Feature:
- Macro: PATTERN_PARITY_EN.
- When defined:
  - Each frame is WIDTH+1 bits. After shadow[0], one extra bit equal to the XOR of all shadow bits is sent (even parity over the frame), with data_valid=1.
  - Busy length becomes N*(WIDTH+1) + (N-1)*GAP_CYCLES.
- When undefined:
  - Frames are exactly WIDTH bits, and no parity logic is synthesized.

Test Plan (WIDTH=3, CNT_W=8):
1. Reset: hold rst=1 for 2 cycles with start=1 -> data_out=0, data_valid=0, busy=0, done=0 throughout. No burst starts after rst drops until a new start.
2. Single frame, GAP_CYCLES=0: pattern=3'b101, repeat_cnt=1, 1-cycle start -> data_out 1,0,1 with data_valid=1 for 3 cycles. busy high for 3 cycles. done=1 on the 4th cycle, then idle.
3. Repeat with gap, GAP_CYCLES=2: pattern=3'b101, repeat_cnt=2 -> valid bits 1,0,1, then 2 cycles of valid=0/out=0, then 1,0,1. busy=8 cycles, then one done pulse. A detector on the line fires twice.
4. Back-to-back and ignored start, GAP_CYCLES=0: pattern=3'b110, repeat_cnt=3, start -> 1,1,0,1,1,0,1,1,0 over 9 contiguous valid cycles. A second start with pattern=3'b011 at cycle 4 is ignored, and the stream is unchanged.
5. Zero count and abort:
   - repeat_cnt=0 with start -> busy, data_valid and done all stay 0.
   - Then pattern=3'b101, repeat_cnt=1, start, and assert rst on the 2nd bit -> all outputs 0 next cycle, and done is never pulsed.
   - A following start with pattern=3'b111 -> 1,1,1.
6. PATTERN_PARITY_EN defined:
   - pattern=3'b101, repeat_cnt=1 -> 1,0,1,0 (4 valid cycles), then done.
   - pattern=3'b111 -> 1,1,1,1.
